line_steer_ctrl: RTL and testbench

Closed-loop steering controller downstream of the pclk-domain line tracker. Once per frame it consumes the tracker's centroid/width/detected result and computes a signed steering correction with a proportional (optionally derivative) term. It converts that correction into left/right motor duty cycles and runs a lost-line state machine. The duties drive two glitch-free PWM outputs.

---
 rtl/line_steer_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_steer_ctrl.sv
// rtl/line_steer_ctrl.sv - line-following steering controller with lost-line FSM and shadowed PWM
// Optional derivative term: define LINE_CTRL_KD_EN.
module line_steer_ctrl #(
  parameter int BASE_DUTY      = 128,
  parameter int DUTY_MAX       = 255,
  parameter int KP             = 16,
  parameter int KP_SHIFT       = 4,
  parameter int KD             = 8,
  parameter int KD_SHIFT       = 4,
  parameter int LOST_FRAMES    = 3,
  parameter int SEARCH_FRAMES  = 30,
  parameter int SEARCH_DUTY    = 100,
  parameter int PWM_DIV        = 4,
  parameter int DEFAULT_CENTER = 160
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        centroid_valid,
  input  logic        detected,
  input  logic [15:0] centroid_x,
  input  logic [15:0] width_px,
  output logic [7:0]  duty_l,
  output logic [7:0]  duty_r,
  output logic        pwm_l,
  output logic        pwm_r,
  output logic [2:0]  state,
  output logic        line_lost
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRACK  = 3'd1,
    S_COAST  = 3'd2,
    S_SEARCH = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic signed [27:0] KP_W   = 28'(KP);
  localparam logic signed [9:0]  BASE_W = 10'(BASE_DUTY);
  localparam logic signed [9:0]  DMAX_W = 10'(DUTY_MAX);
  localparam logic [7:0]         SD_W   = 8'(SEARCH_DUTY);
  localparam logic [7:0]         LOST_W = 8'(LOST_FRAMES);
  localparam logic [7:0]         SRCH_W = 8'(SEARCH_FRAMES);
  localparam logic [15:0]        DIV_W  = 16'(PWM_DIV - 1);

  state_t             st;
  logic               v1;
  logic signed [16:0] err_q;
  logic [7:0]         miss_cnt, frame_cnt, miss_inc, frame_inc;
  logic [7:0]         cmp_l, cmp_r, cmp_l_n, cmp_r_n;
  logic [7:0]         shd_l_n, shd_r_n;
  logic [15:0]        pre;
  logic [7:0]         cnt, cnt_n;
  logic               tick, wrap;
  logic [15:0]        center;
  logic signed [16:0] err_in;
  logic signed [27:0] sum;
  logic signed [9:0]  steer, l_sum, r_sum;

`ifdef LINE_CTRL_KD_EN
  localparam logic signed [27:0] KD_W = 28'(KD);
  logic signed [16:0] prev_err;
`endif

  function automatic logic [7:0] clamp_duty(input logic signed [9:0] v);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > DMAX_W)
      return DMAX_W[7:0];
    else
      return v[7:0];
  endfunction

  assign state     = st;
  assign miss_inc  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
  assign frame_inc = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;

  always_comb begin
    center = (width_px == 16'd0) ? 16'(DEFAULT_CENTER) : (width_px >> 1);
    err_in = $signed({1'b0, centroid_x}) - $signed({1'b0, center});
  end

  // err_q always holds the most recent TRACK error; it also sets the search spin direction.
  always_comb begin
    sum = (28'(err_q) * KP_W) >>> KP_SHIFT;
`ifdef LINE_CTRL_KD_EN
    sum = sum + (((28'(err_q) - 28'(prev_err)) * KD_W) >>> KD_SHIFT);
`endif
    if (sum > 28'sd255)
      steer = 10'sd255;
    else if (sum < -28'sd255)
      steer = -10'sd255;
    else
      steer = sum[9:0];
    l_sum = BASE_W + steer;
    r_sum = BASE_W - steer;
  end

  always_comb begin
    cmp_l_n = cmp_l;
    cmp_r_n = cmp_r;
    if (!en) begin
      cmp_l_n = 8'd0;
      cmp_r_n = 8'd0;
    end else if (v1) begin
      case (st)
        S_TRACK: begin
          cmp_l_n = clamp_duty(l_sum);
          cmp_r_n = clamp_duty(r_sum);
        end
        S_COAST: ;
        S_SEARCH: begin
          cmp_l_n = err_q[16] ? 8'd0 : SD_W;
          cmp_r_n = err_q[16] ? SD_W : 8'd0;
        end
        default: begin
          cmp_l_n = 8'd0;
          cmp_r_n = 8'd0;
        end
      endcase
    end
  end

  // Shadows only move on counter wrap so a PWM period never mixes two duties.
  always_comb begin
    tick    = (pre == DIV_W);
    wrap    = tick && (cnt == 8'hFF);
    cnt_n   = tick ? cnt + 8'd1 : cnt;
    shd_l_n = !en ? 8'd0 : (wrap ? cmp_l_n : duty_l);
    shd_r_n = !en ? 8'd0 : (wrap ? cmp_r_n : duty_r);
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      st        <= S_IDLE;
      line_lost <= 1'b0;
      v1        <= 1'b0;
      err_q     <= '0;
      miss_cnt  <= '0;
      frame_cnt <= '0;
      cmp_l     <= '0;
      cmp_r     <= '0;
      duty_l    <= '0;
      duty_r    <= '0;
      pwm_l     <= 1'b0;
      pwm_r     <= 1'b0;
      pre       <= '0;
      cnt       <= '0;
`ifdef LINE_CTRL_KD_EN
      prev_err  <= '0;
`endif
    end else begin
      pre    <= tick ? 16'd0 : pre + 16'd1;
      cnt    <= cnt_n;
      cmp_l  <= cmp_l_n;
      cmp_r  <= cmp_r_n;
      duty_l <= shd_l_n;
      duty_r <= shd_r_n;
      pwm_l  <= (cnt_n < shd_l_n);
      pwm_r  <= (cnt_n < shd_r_n);
      if (!en) begin
        st        <= S_IDLE;
        line_lost <= 1'b0;
        v1        <= 1'b0;
        miss_cnt  <= '0;
        frame_cnt <= '0;
      end else begin
        v1 <= centroid_valid;
        if (centroid_valid) begin
          if (detected) begin
            st        <= S_TRACK;
            line_lost <= 1'b0;
            miss_cnt  <= '0;
            frame_cnt <= '0;
            err_q     <= err_in;
`ifdef LINE_CTRL_KD_EN
            prev_err  <= (st == S_TRACK) ? err_q : err_in;
`endif
          end else begin
            case (st)
              S_SEARCH: begin
                frame_cnt <= frame_inc;
                if (frame_inc >= SRCH_W)
                  st <= S_STOP;
              end
              S_STOP: ;
              default: begin
                miss_cnt <= miss_inc;
                if (miss_inc >= LOST_W) begin
                  st        <= S_SEARCH;
                  line_lost <= 1'b1;
                  frame_cnt <= '0;
                end else begin
                  st <= S_COAST;
                end
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_steer_ctrl.sv
// tb/tb_line_steer_ctrl.sv - scoreboard bench for line_steer_ctrl
module tb_line_steer_ctrl;

  logic        pclk = 1'b0;
  logic        reset_n, en, centroid_valid, detected;
  logic [15:0] centroid_x, width_px;
  logic [7:0]  duty_l, duty_r;
  logic        pwm_l, pwm_r, line_lost;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] l;
    logic [7:0] r;
    logic       lost;
  } exp_t;
  exp_t sb[$];

`ifdef LINE_CTRL_KD_EN
  localparam int S2_L = 188, S2_R = 68, S4_L = 108, S4_R = 148;
  localparam int S10_L = 108, S10_R = 148, S11_L = 188, S11_R = 68;
`else
  localparam int S2_L = 168, S2_R = 88, S4_L = 168, S4_R = 88;
  localparam int S10_L = 128, S10_R = 128, S11_L = 168, S11_R = 88;
`endif

  line_steer_ctrl dut (
    .pclk(pclk), .reset_n(reset_n), .en(en),
    .centroid_valid(centroid_valid), .detected(detected),
    .centroid_x(centroid_x), .width_px(width_px),
    .duty_l(duty_l), .duty_r(duty_r), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .state(state), .line_lost(line_lost)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int st, input int l, input int r, input bit lost);
    exp_t e;
    e.tag = tag; e.st = 3'(st); e.l = 8'(l); e.r = 8'(r); e.lost = lost;
    sb.push_back(e);
  endtask

  task automatic send(input int cx, input int w, input bit det);
    centroid_x = 16'(cx); width_px = 16'(w); detected = det; centroid_valid = 1'b1;
    @(negedge pclk);
    centroid_valid = 1'b0;
    @(negedge pclk);
  endtask

  // Waits long enough for at least one counter wrap, then compares against the oldest expectation.
  task automatic settle_check();
    exp_t e;
    repeat (1100) @(negedge pclk);
    e = sb.pop_front();
    chk({e.tag, "_state"}, state, e.st);
    chk({e.tag, "_duty_l"}, duty_l, e.l);
    chk({e.tag, "_duty_r"}, duty_r, e.r);
    chk({e.tag, "_lost"}, line_lost, e.lost);
  endtask

  task automatic wait_rise(input string tag);
    int n;
    logic prev;
    prev = pwm_l;
    @(negedge pclk);
    n = 1;
    while (!(prev === 1'b0 && pwm_l === 1'b1) && n < 2200) begin
      prev = pwm_l;
      @(negedge pclk);
      n++;
    end
    chk({tag, "_rise_seen"}, 32'(n < 2200), 1);
  endtask

  initial begin
    int hi;
    reset_n = 1'b0; en = 1'b0; centroid_valid = 1'b0; detected = 1'b0;
    centroid_x = '0; width_px = '0;
    repeat (3) @(negedge pclk);
    chk("rst_state", state, 0);
    chk("rst_duty_l", duty_l, 0);
    chk("rst_duty_r", duty_r, 0);
    chk("rst_pwm", {pwm_l, pwm_r}, 0);
    chk("rst_lost", line_lost, 0);
    reset_n = 1'b1; en = 1'b1;
    repeat (5) @(negedge pclk);
    chk("idle_wait", state, 0);

    push("center", 1, 128, 128, 0);        send(160, 320, 1); settle_check();
    push("p40", 1, S2_L, S2_R, 0);         send(200, 320, 1); settle_check();
    push("clamp", 1, 255, 0, 0);           send(319, 320, 1); settle_check();
    push("p40b", 1, S4_L, S4_R, 0);        send(200, 320, 1); settle_check();
    push("miss1", 2, S4_L, S4_R, 0);       send(0, 320, 0);   settle_check();
    push("miss2", 2, S4_L, S4_R, 0);       send(0, 320, 0);   settle_check();
    push("miss3", 3, 100, 0, 1);           send(0, 320, 0);   settle_check();

    for (int i = 0; i < 29; i++) send(0, 320, 0);
    chk("search29_state", state, 3);
    push("stop", 4, 0, 0, 1);              send(0, 320, 0);   settle_check();

    hi = 0;
    repeat (1100) begin
      @(negedge pclk);
      if (pwm_l || pwm_r) hi++;
    end
    chk("stop_pwm_high_cycles", hi, 0);

    push("reacquire", 1, 168, 88, 0);      send(200, 320, 1); settle_check();

    // New duty lands mid-period; the running period must keep the old width.
    push("w0_center", 1, S10_L, S10_R, 0);
    wait_rise("glitch1");
    hi = 0;
    while (pwm_l === 1'b1 && hi < 2000) begin
      hi++;
      if (hi == 40) begin
        centroid_x = 16'd160; width_px = 16'd0; detected = 1'b1; centroid_valid = 1'b1;
      end
      if (hi == 41) centroid_valid = 1'b0;
      @(negedge pclk);
    end
    chk("glitch_old_period", hi, 168 * 4);
    wait_rise("glitch2");
    hi = 0;
    while (pwm_l === 1'b1 && hi < 2000) begin
      hi++;
      @(negedge pclk);
    end
    chk("glitch_new_period", hi, S10_L * 4);
    settle_check();

    push("p40c", 1, S11_L, S11_R, 0);      send(200, 320, 1); settle_check();
    wait_rise("disable");
    repeat (200) @(negedge pclk);
    chk("dis_pwm_before", pwm_l, 1);
    en = 1'b0;
    @(negedge pclk);
    chk("dis_pwm_l", pwm_l, 0);
    chk("dis_pwm_r", pwm_r, 0);
    chk("dis_state", state, 0);
    chk("dis_duty", {duty_l, duty_r}, 0);

    // Strobe coinciding with en falling is discarded.
    en = 1'b1;
    @(negedge pclk);
    en = 1'b0; centroid_x = 16'd200; width_px = 16'd320; detected = 1'b1; centroid_valid = 1'b1;
    @(negedge pclk);
    centroid_valid = 1'b0;
    en = 1'b1;
    repeat (1100) @(negedge pclk);
    chk("en_wins_state", state, 0);
    chk("en_wins_duty", {duty_l, duty_r}, 0);

    push("idle_miss", 2, 0, 0, 0);         send(0, 320, 0);   settle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
